demux_stream: RTL
=================

// Module: demux_stream
//
// PURPOSE
// Registered stream demultiplexer: routes one valid/ready input stream to one of
// 2**SEL_WIDTH output streams, packed into a single output bus with one
// DATA_WIDTH slice per channel. It sits on the distribution side of the packed-bus
// muxes: one source fans out to N consumers. Routing is locked per packet
// (in_last). Each channel has a one-entry output register and independent backpressure.
//
// PARAMETERS
// SEL_WIDTH   2   number of select bits; N = 2**SEL_WIDTH output channels
// DATA_WIDTH  8   width of each data beat / output slice
//
// PORTS
// clk        in   1              clock, all logic on posedge
// rst        in   1              synchronous reset, active-high
// in_valid   in   1              input beat valid
// in_ready   out  1              input beat accepted when in_valid & in_ready
// in_sel     in   SEL_WIDTH      destination channel; sampled on first beat of packet only
// in_data    in   DATA_WIDTH     input beat data
// in_last    in   1              final beat of packet
// out_valid  out  N              per-channel output valid
// out_ready  in   N              per-channel consumer ready
// outputs    out  DATA_WIDTH*N   packed outputs; channel i = outputs[DATA_WIDTH*i +: DATA_WIDTH]
// out_last   out  N              per-channel last flag for the held beat
//
// BEHAVIOUR
// - FSM, 2 states: IDLE (no packet open), BUSY (packet open, route locked to cur_sel).
// - Target t = (state==IDLE) ? in_sel : cur_sel.
// - in_ready = ~rst & (~out_valid[t] | out_ready[t]); combinational, full throughput.
// - Accept in IDLE: cur_sel <= in_sel; state <= in_last ? IDLE : BUSY.
// - Accept in BUSY: in_sel ignored; state <= in_last ? IDLE : BUSY.
// - On accept: slice t <= in_data, out_last[t] <= in_last, out_valid[t] <= 1 next cycle.
//   Latency: accept at cycle k -> visible on outputs at cycle k+1.
// - Drain: out_valid[i] & out_ready[i] with no load to i -> out_valid[i] <= 0.
//   Simultaneous drain + load on same channel -> new beat loaded, out_valid stays 1.
// - Slices/out_last of non-loaded channels hold their value (never zeroed on drain).
// - Channels are independent: a stalled channel never blocks beats to other channels,
//   except that an open packet blocks the input until its own channel frees.
// - in_valid & ~in_ready: nothing accepted, no state change; source holds beat.
// - Reset (also mid-packet): out_valid=0, outputs=0, out_last=0, cur_sel=0,
//   state=IDLE, in_ready=0 while rst high; held beats discarded; first beat after
//   reset is treated as packet start.
// - Ordering: beats on any one channel appear in acceptance order, no loss/duplication.
//
// TESTING (SEL_WIDTH=2, DATA_WIDTH=8)
// 1. rst=1 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=4'b0000,
//    outputs=32'h0, out_last=0; nothing captured after rst drops.
// 2. out_ready=4'hF; beat sel=2 data=8'hA5 last=1 -> next cycle out_valid=4'b0100,
//    outputs[23:16]=8'hA5, out_last[2]=1; out_valid returns to 0 the cycle after.
// 3. 3-beat packet data 8'h01,02,03, in_sel=1 then 3, 0 on beats 2/3 -> all three on
//    ch1 in order, last on 03; following packet sel=3 data 8'h44 -> ch3.
// 4. out_ready[0]=0; beats 8'h11 then 8'h22 to ch0 -> 11 held, in_ready=0 for 22;
//    raise out_ready[0] -> 11 consumed then 22, no loss, no duplicate.
// 5. out_ready=4'hF; 8 back-to-back single-beat packets to ch 0,1,2,3,0,1,2,3 ->
//    in_ready stays 1, one beat per cycle, each slice updated in turn.
// 6. Open packet to ch2 (1 beat, last=0), rst 1 cycle -> out_valid=0, state IDLE;
//    next beat sel=0 data 8'h5A last=1 -> appears on ch0 only.

Source files
------------

// File: rtl/demux_stream.sv
// Registered packet-locked stream demultiplexer: one valid/ready source fans out
// to 2**SEL_WIDTH consumers, each with a one-entry output register.
module demux_stream #(
    parameter int SEL_WIDTH  = 2,
    parameter int DATA_WIDTH = 8,
    localparam int N = 2 ** SEL_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_WIDTH-1:0]    in_sel,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_last,
    output logic [N-1:0]            out_valid,
    input  logic [N-1:0]            out_ready,
    output logic [DATA_WIDTH*N-1:0] outputs,
    output logic [N-1:0]            out_last
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state_reg, state_next;
    logic [SEL_WIDTH-1:0] cur_sel_reg, cur_sel_next;
    logic [SEL_WIDTH-1:0] target;
    logic                 accept;

    // in_sel only matters on the first beat; later beats follow the locked route.
    assign target   = (state_reg == IDLE) ? in_sel : cur_sel_reg;
    assign in_ready = ~rst & (~out_valid[target] | out_ready[target]);
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_next   = state_reg;
        cur_sel_next = cur_sel_reg;
        if (accept) begin
            cur_sel_next = target;
            state_next   = in_last ? IDLE : BUSY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            cur_sel_reg <= '0;
        end else begin
            state_reg   <= state_next;
            cur_sel_reg <= cur_sel_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_ch
            logic                  load;
            logic                  valid_reg;
            logic                  last_reg;
            logic [DATA_WIDTH-1:0] data_reg;

            assign load = accept & (target == SEL_WIDTH'(gi));

            // A load wins over a drain so a draining slot can be refilled in the same cycle.
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg <= 1'b0;
                    last_reg  <= 1'b0;
                    data_reg  <= '0;
                end else if (load) begin
                    valid_reg <= 1'b1;
                    last_reg  <= in_last;
                    data_reg  <= in_data;
                end else if (valid_reg & out_ready[gi]) begin
                    valid_reg <= 1'b0;
                end
            end

            assign out_valid[gi]                            = valid_reg;
            assign out_last[gi]                             = last_reg;
            assign outputs[DATA_WIDTH*gi +: DATA_WIDTH]     = data_reg;
        end
    endgenerate

endmodule
